// File: rtl/bus_arbiter_4.sv
// Four-requester bus arbiter with a circular-priority search and a registered grant.
// A grant is held until the resource signals done or the requester drops its request.
// Optional watchdog: define ARB_TIMEOUT_EN to revoke grants held for TIMEOUT cycles.
module bus_arbiter_4 #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic [31:0] in3,
  input  logic        done,
  output logic [3:0]  grant,
  output logic [1:0]  sel,
  output logic        busy,
  output logic [31:0] out,
  output logic        timeout
);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [3:0]  grant_q, grant_d;
  logic [1:0]  sel_q, sel_d;
  logic        busy_q, busy_d;
  logic        timeout_q, timeout_d;

  logic [1:0]  pick;
  logic        expire;
  logic        end_busy;

  // Any end event while busy; done and abort together still count as one end.
  assign end_busy = done | ~req[sel_q] | expire;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expire = (state_q == StBusy) && (cnt_q == CntW'(TIMEOUT - 1));

  // Watchdog count: cycles spent in the current grant, zero whenever idle.
  always_comb begin
    cnt_d = '0;
    if (state_q == StBusy && !end_busy) cnt_d = cnt_q + CntW'(1);
  end

  // Watchdog count register.
  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic unused_timeout_cfg;

  assign expire             = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT == 0);
`endif

  // Circular search for the first active request starting at ptr.
  always_comb begin
    logic [1:0] idx;
    logic       found;
    pick  = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // Next-state logic: grant from idle, release on any end event.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (|req) begin
          state_d = StBusy;
          grant_d = 4'b0001 << pick;
          sel_d   = pick;
          busy_d  = 1'b1;
        end
      end
      StBusy: begin
        if (end_busy) begin
          state_d   = StIdle;
          ptr_d     = sel_q + 2'd1;
          grant_d   = 4'b0000;
          busy_d    = 1'b0;
          timeout_d = expire & ~done;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      ptr_q     <= 2'd0;
      grant_q   <= 4'b0000;
      sel_q     <= 2'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  // Shared data mux, forced to zero while idle.
  always_comb begin
    out = 32'h0;
    if (busy_q) begin
      case (sel_q)
        2'd0:    out = in0;
        2'd1:    out = in1;
        2'd2:    out = in2;
        default: out = in3;
      endcase
    end
  end

  assign grant   = grant_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter_4.sv
// Directed bench for bus_arbiter_4; watchdog checks follow ARB_TIMEOUT_EN.
module tb_bus_arbiter_4;

  localparam logic [31:0] D0 = 32'hA0A0_0000;
  localparam logic [31:0] D1 = 32'hB1B1_1111;
  localparam logic [31:0] D2 = 32'hC2C2_2222;
  localparam logic [31:0] D3 = 32'hD3D3_3333;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] in0, in1, in2, in3;
  logic        done;
  logic [3:0]  grant;
  logic [1:0]  sel;
  logic        busy;
  logic [31:0] out;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  bus_arbiter_4 #(.TIMEOUT(16)) dut (
    .clock  (clock),
    .reset  (reset),
    .req    (req),
    .in0    (in0),
    .in1    (in1),
    .in2    (in2),
    .in3    (in3),
    .done   (done),
    .grant  (grant),
    .sel    (sel),
    .busy   (busy),
    .out    (out),
    .timeout(timeout)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_out"}, out, 32'h0);
  endtask

  task automatic check_grant(input string tag, input logic [3:0] g, input logic [1:0] s,
                             input logic [31:0] d);
    check({tag, "_grant"}, 32'(grant), 32'(g));
    check({tag, "_sel"}, 32'(sel), 32'(s));
    check({tag, "_busy"}, 32'(busy), 32'h1);
    check({tag, "_out"}, out, d);
  endtask

  initial begin
    logic [3:0] order [5];
    logic [1:0] oidx [5];
    logic [31:0] odat [5];
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    oidx  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    odat  = '{D0, D1, D2, D3, D0};

    reset = 1'b1; req = 4'b0000; done = 1'b0;
    in0 = D0; in1 = D1; in2 = D2; in3 = D3;
    step(); step();
    check_idle("reset");
    check("reset_sel", 32'(sel), 32'h0);
    check("reset_timeout", 32'(timeout), 32'h0);
    reset = 1'b0;

    // Single requester, grant one cycle later, release on done.
    req = 4'b0001;
    step();
    check_grant("single", 4'b0001, 2'd0, D0);
    done = 1'b1; req = 4'b0000;
    step();
    check_idle("single_done");
    done = 1'b0;

    // Re-align ptr to 0, then full round robin with done every third cycle.
    reset = 1'b1; step(); reset = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      check_grant("rr", order[k], oidx[k], odat[k]);
      step();
      check("rr_hold", 32'(grant), 32'(order[k]));
      done = 1'b1;
      if (k == 4) req = 4'b0000;
      step();
      done = 1'b0;
      check_idle("rr_gap");
    end

    // ptr=1: requester 2 wins, then aborts by dropping its request.
    req = 4'b0100;
    step();
    check_grant("abort_pre", 4'b0100, 2'd2, D2);
    req = 4'b0000;
    step();
    check_idle("abort");
    check("abort_timeout", 32'(timeout), 32'h0);

    // ptr=3: search wraps to requester 1, then requester 2 next.
    req = 4'b0110;
    step();
    check_grant("wrap", 4'b0010, 2'd1, D1);
    done = 1'b1;
    step();
    done = 1'b0;
    check_idle("wrap_gap");
    step();
    check_grant("wrap_next", 4'b0100, 2'd2, D2);

    // done and abort together end the grant once, no timeout.
    done = 1'b1; req = 4'b0000;
    step();
    check_idle("done_abort");
    check("done_abort_timeout", 32'(timeout), 32'h0);

    // done ignored while idle.
    step();
    check_idle("idle_done");
    done = 1'b0;

    // ptr=3: requester 3 granted, then reset mid-grant.
    req = 4'b1000;
    step();
    check_grant("r3", 4'b1000, 2'd3, D3);
    reset = 1'b1;
    step();
    check_idle("mid_reset");
    check("mid_reset_sel", 32'(sel), 32'h0);
    check("mid_reset_timeout", 32'(timeout), 32'h0);
    reset = 1'b0;
    req = 4'b1111;
    step();
    check_grant("post_reset", 4'b0001, 2'd0, D0);

    // Hold the grant with no done.
    req = 4'b0001;
`ifdef ARB_TIMEOUT_EN
    for (int i = 1; i <= 17; i++) begin
      step();
      if (i < 16) begin
        check("wd_hold", 32'(grant), 32'h1);
        check("wd_quiet", 32'(timeout), 32'h0);
      end else if (i == 16) begin
        check("wd_revoke", 32'(grant), 32'h0);
        check("wd_pulse", 32'(timeout), 32'h1);
      end else begin
        check("wd_pulse_end", 32'(timeout), 32'h0);
        check("wd_regrant", 32'(grant), 32'h1);
      end
    end
`else
    for (int i = 0; i < 110; i++) begin
      step();
      check("hold_grant", 32'(grant), 32'h1);
      check("hold_timeout", 32'(timeout), 32'h0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_4.md
BUS_ARBITER_4 -- requirements
Module: bus_arbiter_4

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, meaning the maximum number of cycles one grant may be held (used only when ARB_TIMEOUT_EN is defined).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset; ports are named clock and reset as elsewhere in the codebase.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  4  request from requester i on req[i], level-held until served.
REQ-006 in0, in1, in2, in3  input  32 each  data from requester 0..3.
REQ-007 done  input  1  one-cycle pulse from the shared resource marking end of the current transaction.
REQ-008 grant  output  4  one-hot grant, all zeros when idle.
REQ-009 sel  output  2  registered index of the granted requester; drives the shared 4:1 data mux.
REQ-010 busy  output  1  high while a grant is held.
REQ-011 out  output  32  in[sel] while busy, 32'h0 while idle.
REQ-012 timeout  output  1  one-cycle pulse when a grant is revoked by the watchdog.

Function
REQ-013 The block SHALL implement two states: IDLE and BUSY.
REQ-014 In IDLE with req != 0, the block SHALL choose the first set req bit searching circularly from pointer ptr upward, and enter BUSY on the next edge with grant, sel and busy registered; req-to-grant latency is 1 cycle.
REQ-015 In IDLE with req == 0, the block SHALL stay in IDLE with grant=0 and busy=0.
REQ-016 In BUSY, grant, sel and busy SHALL be held constant until an end event.
REQ-017 End events, all sampled in BUSY: done=1; req[sel]=0 (abort); or the watchdog expiring.
REQ-018 On any end event the block SHALL return to IDLE on the next edge, set ptr = sel+1 (mod 4), and clear grant and busy. No new grant is issued in that cycle, so grants are separated by at least one IDLE cycle.
REQ-019 If done and the abort condition occur in the same cycle, the block SHALL treat the cycle as a single normal end event.
REQ-020 The block SHALL ignore done while in IDLE.
REQ-021 out SHALL be combinational from sel and the in0..in3 inputs, gated by busy.
REQ-022 ptr SHALL be 2 bits wide and wrap from 3 to 0.
REQ-023 A requester SHALL NOT be granted twice in a row while any other requester is requesting.

Reset
REQ-024 While reset is high, the block SHALL force state=IDLE, ptr=0, grant=4'b0000, sel=2'b00, busy=0, timeout=0, watchdog count=0, and out=32'h0.
REQ-025 Reset asserted in BUSY SHALL drop grant on the next edge without raising timeout.
REQ-026 The first grant after reset SHALL favour requester 0.

Configuration
REQ-027 With macro ARB_TIMEOUT_EN defined, the block SHALL count cycles in BUSY from 0. When the count reaches TIMEOUT-1 without done, the grant ends per REQ-018 and timeout pulses high for exactly 1 cycle, on the cycle the block re-enters IDLE.
REQ-028 With ARB_TIMEOUT_EN undefined, the block SHALL contain no counter, timeout SHALL be tied 0, and a grant is held until done or abort.
REQ-029 done in the same cycle as expiry SHALL end the grant normally, with no timeout pulse.

Verification
REQ-030 Reset, then req=4'b0001 -> grant=4'b0001, sel=0, busy=1 one cycle later; out=in0; done pulse -> grant=0 on the next cycle.
REQ-031 req=4'b1111 held, done every 3rd cycle -> grants in the order 0,1,2,3,0 with one IDLE cycle between each grant.
REQ-032 req=4'b0110 with ptr=3 -> grant=4'b0010 (wraps to requester 1); after done, requester 2 is granted next.
REQ-033 Requester 2 granted, then req[2] dropped without done -> back to IDLE the next cycle, ptr=3, no timeout.
REQ-034 ARB_TIMEOUT_EN defined, TIMEOUT=16, grant held with no done -> timeout=1 for exactly 1 cycle, 16 cycles after the grant; ARB_TIMEOUT_EN undefined -> grant held for 100+ cycles.
REQ-035 Reset asserted mid-BUSY with requester 3 granted -> all outputs zero on the next edge, and the next grant favours requester 0.
